// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial add/sub scheduler: FSM states and requester count.
package serial_add_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sas_state_t;

    localparam int NUM_REQ = 2;

endpackage

// File: rtl/fa_cell_ff.sv
// Single full-adder cell with registered sum and carry; the only arithmetic in the serial datapath.
module fa_cell_ff (
    input  logic clk,
    input  logic reset,
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s_q,
    output logic cout_q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q    <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= x ^ y ^ cin;
            cout_q <= (x & y) | (cin & (x ^ y));
        end
    end

endmodule

// File: rtl/serial_add_sched.sv
// Round-robin scheduler of two requesters onto one clocked full-adder cell,
// streaming operands LSB-first and returning the result over valid/ready.
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req0_sub,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    input  logic               req1_sub,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_sum,
    output logic               rsp_cout,
    output logic               rsp_ovf
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sas_state_t         state, state_next;
    logic               ptr;
    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic               accept_id;
    logic               sel_sub;
    logic [WIDTH-1:0]   a_sh, b_sh, sum_sh;
    logic [CNT_W-1:0]   cnt;
    logic               sub_q, id_q, c_msb_in;
    logic               cell_cin, s_q, cout_q;

    // Forcing cin from sub on the first bit keeps the previous op's carry out.
    assign cell_cin = (cnt == '0) ? sub_q : cout_q;

    fa_cell_ff u_fa (
        .clk    (clk),
        .reset  (reset),
        .x      (a_sh[0]),
        .y      (b_sh[0]),
        .cin    (cell_cin),
        .s_q    (s_q),
        .cout_q (cout_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant      = '0;
        req_ready  = '0;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
        if (state == IDLE) begin
            req_ready = req_valid & grant;
        end
        accept    = |req_ready;
        accept_id = req_ready[1];
        sel_sub   = accept_id ? req1_sub : req0_sub;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (cnt == CNT_LAST) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    if (rsp_valid && rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The first DONE cycle publishes the assembled sum; later DONE cycles wait for the consumer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            cnt       <= '0;
            sub_q     <= 1'b0;
            id_q      <= 1'b0;
            c_msb_in  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh  <= accept_id ? req1_a : req0_a;
                        b_sh  <= (accept_id ? req1_b : req0_b) ^ {WIDTH{sel_sub}};
                        sub_q <= sel_sub;
                        id_q  <= accept_id;
                        cnt   <= '0;
                        ptr   <= ~accept_id;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt != '0) begin
                        sum_sh <= {s_q, sum_sh[WIDTH-1:1]};
                    end
                    if (cnt == CNT_LAST) begin
                        c_msb_in <= cout_q;
                    end
                end
                DRAIN: begin
                    sum_sh   <= {s_q, sum_sh[WIDTH-1:1]};
                    rsp_cout <= cout_q;
                    rsp_ovf  <= c_msb_in ^ cout_q;
                    rsp_id   <= id_q;
                end
                DONE: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_sum   <= sum_sh;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed self-checking bench for serial_add_sched with hand-computed expected results.
module tb_serial_add_sched;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_sub, req1_sub;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
    logic [15:0] rsp_sum;

    int total = 0;
    int bad   = 0;

    serial_add_sched #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_sub  (req0_sub),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_sub  (req1_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_valid"}, 32'(rsp_valid), 0);
        check_output({tag, "_sum"}, 32'(rsp_sum), 0);
        check_output({tag, "_id"}, 32'(rsp_id), 0);
        check_output({tag, "_cout"}, 32'(rsp_cout), 0);
        check_output({tag, "_ovf"}, 32'(rsp_ovf), 0);
        check_output({tag, "_rdy"}, 32'(req_ready), 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Issue one op on a single requester, check latency and result fields.
    task automatic apply_stimulus(input string tag, input logic id, input logic [15:0] a,
                                  input logic [15:0] b, input logic sub, input logic [15:0] exp_sum,
                                  input logic exp_cout, input logic exp_ovf);
        bit got;
        int lat;
        if (id) begin
            req1_a = a; req1_b = b; req1_sub = sub;
        end else begin
            req0_a = a; req0_b = b; req0_sub = sub;
        end
        req_valid[id] = 1'b1;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1;
                break;
            end
        end
        check_output({tag, "_accept"}, 32'(got), 1);
        if (!got) begin
            req_valid[id] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
        got = 0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                got = 1;
                lat = i;
                break;
            end
        end
        check_output({tag, "_latency"}, 32'(lat), 18);
        check_output({tag, "_id"}, 32'(rsp_id), 32'(id));
        check_output({tag, "_sum"}, 32'(rsp_sum), 32'(exp_sum));
        check_output({tag, "_cout"}, 32'(rsp_cout), 32'(exp_cout));
        check_output({tag, "_ovf"}, 32'(rsp_ovf), 32'(exp_ovf));
        if (got && rsp_ready) begin
            @(posedge clk);
            #1 check_output({tag, "_drop"}, 32'(rsp_valid), 0);
        end
    endtask

    initial begin
        int busy_ready;
        bit got;
        reset     = 1'b1;
        req_valid = 2'b00;
        req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check_all_zero("rst");
        apply_reset();
        check_all_zero("post_rst");

        apply_stimulus("s1", 1'b0, 16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0);
        apply_stimulus("s2", 1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        apply_stimulus("s3a", 1'b0, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        apply_stimulus("s3b", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Stalled consumer: response must stay frozen until rsp_ready rises.
        rsp_ready = 1'b0;
        apply_stimulus("s5", 1'b1, 16'h1000, 16'h0234, 1'b0, 16'h1234, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_output("s5_hold_valid", 32'(rsp_valid), 1);
            check_output("s5_hold_sum", 32'(rsp_sum), 32'h1234);
            check_output("s5_hold_id", 32'(rsp_id), 1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 check_output("s5_release", 32'(rsp_valid), 0);

        // Both requesters contending from a fresh pointer: expect 0,1,0,1.
        apply_reset();
        req0_a = 16'h0100; req0_b = 16'h0023; req0_sub = 1'b0;
        req1_a = 16'h8000; req1_b = 16'h0001; req1_sub = 1'b1;
        req_valid  = 2'b11;
        busy_ready = 0;
        for (int op = 0; op < 4; op++) begin
            got = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (req_ready != 2'b00) begin
                    got = 1;
                    break;
                end
            end
            check_output("s4_grant", 32'(req_ready), (op % 2 == 1) ? 2 : 1);
            @(posedge clk);
            got = 0;
            for (int i = 0; i < 40; i++) begin
                #1;
                if (req_ready != 2'b00) busy_ready++;
                if (rsp_valid) begin
                    got = 1;
                    break;
                end
                @(posedge clk);
            end
            check_output("s4_valid", 32'(got), 1);
            check_output("s4_id", 32'(rsp_id), 32'(op % 2));
            check_output("s4_sum", 32'(rsp_sum), (op % 2 == 1) ? 32'h7FFF : 32'h0123);
            if (op % 2 == 1) begin
                check_output("s4_cout", 32'(rsp_cout), 1);
                check_output("s4_ovf", 32'(rsp_ovf), 1);
            end
        end
        req_valid = 2'b00;
        check_output("s4_busy_ready", 32'(busy_ready), 0);
        @(posedge clk);
        #1;

        // Reset in the middle of RUN (k=7) of a requester-0 op.
        req0_a = 16'hAAAA; req0_b = 16'h5555; req0_sub = 1'b0;
        req_valid = 2'b01;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready[0]) begin
                got = 1;
                break;
            end
        end
        check_output("s6_accept", 32'(got), 1);
        @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (7) @(posedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("s6_async");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        check_output("s6_ptr", 32'(req_ready), 1);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        apply_stimulus("s6_after", 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
